// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD FIFO printer: opcodes, command-word fields, FSM states.
package lcd_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ARG_W    = 24;
  localparam int unsigned LCD_DW   = 16;
  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 30;
  localparam int unsigned BL_BIT   = 24;
  localparam int unsigned RSTP_BIT = 25;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_WRLO,
    ST_WRHI,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter with a done flag; paces the write strobe phases and delays.
module lcd_cycle_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Phase ends in the cycle the count shows 1, so a load of N spans N cycles.
  assign done_c = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/lcd_fifo_printer.sv
// Pops command words from the FIFO and plays them out on the LCD 8080 bus,
// as register/data writes, timed delays, or backlight / panel-reset control.
module lcd_fifo_printer
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2,
  parameter int unsigned CNT_W       = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rempty,
  input  logic [WORD_W-1:0] rdata,
  output logic              rinc,
  output logic              busy,
  output logic              LCD_CS,
  output logic              LCD_RS,
  output logic              LCD_WR,
  output logic              LCD_RD,
  output logic              LCD_RST,
  output logic              LCD_BL,
  output logic [LCD_DW-1:0] LCD_DATA
);

  state_e            state_q, state_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic              rinc_q, rinc_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              rs_q, rs_d;
  logic              wr_q, wr_d;
  logic              lrst_q, lrst_d;
  logic              bl_q, bl_d;
  logic [LCD_DW-1:0] data_q, data_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_done_c;

  logic [1:0]        op_c;
  logic [ARG_W-1:0]  arg_c;
  logic              unused_rsvd;

  assign op_c        = rdata[OP_HI:OP_LO];
  assign arg_c       = rdata[ARG_W-1:0];
  assign unused_rsvd = ^rdata[29:26];

  lcd_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done_c   (tmr_done_c)
  );

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = 1'b0;
    rinc_d     = 1'b0;
    cs_d       = cs_q;
    rs_d       = rs_q;
    wr_d       = wr_q;
    lrst_d     = lrst_q;
    bl_d       = bl_q;
    data_d     = data_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rempty) begin
          rinc_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      // First FETCH cycle lets the FIFO register the popped word onto rdata.
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          case (op_c)
            OP_CMD, OP_DATA: begin
              rs_d    = (op_c == OP_DATA);
              data_d  = arg_c[LCD_DW-1:0];
              cs_d    = 1'b0;
              state_d = ST_SETUP;
            end
            OP_DELAY: begin
              if (arg_c != '0) begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(arg_c);
                state_d  = ST_WAIT;
              end
            end
            default: begin
              bl_d = rdata[BL_BIT];
              if (rdata[RSTP_BIT] && (arg_c != '0)) begin
                lrst_d   = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(arg_c);
                state_d  = ST_WAIT;
              end
            end
          endcase
        end
      end
      ST_SETUP: begin
        wr_d     = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(WR_LOW_CYC);
        state_d  = ST_WRLO;
      end
      ST_WRLO: begin
        if (tmr_done_c) begin
          wr_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(WR_HIGH_CYC);
          state_d  = ST_WRHI;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WRHI: begin
        if (tmr_done_c) begin
          cs_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        if (tmr_done_c) begin
          lrst_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_ph_q <= 1'b0;
      rinc_q     <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      rs_q       <= 1'b0;
      wr_q       <= 1'b1;
      lrst_q     <= 1'b1;
      bl_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      rinc_q     <= rinc_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      rs_q       <= rs_d;
      wr_q       <= wr_d;
      lrst_q     <= lrst_d;
      bl_q       <= bl_d;
      data_q     <= data_d;
    end
  end

  assign rinc     = rinc_q;
  assign busy     = busy_q;
  assign LCD_CS   = cs_q;
  assign LCD_RS   = rs_q;
  assign LCD_WR   = wr_q;
  assign LCD_RD   = 1'b1;
  assign LCD_RST  = lrst_q;
  assign LCD_BL   = bl_q;
  assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_fifo_printer.sv
// Directed bench for lcd_fifo_printer with a registered-read FIFO model.
module tb_lcd_fifo_printer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rempty;
  logic [31:0] rdata;
  logic        rinc, busy, LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL;
  logic [15:0] LCD_DATA;

  logic [31:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int errors = 0;
  int checks = 0;

  int cyc, rinc_cnt, rinc_first, rinc_last, busy_cnt, run, run_max;
  int cs_cnt, wr_cnt, rstl_cnt, frames, viol;
  logic [15:0] frame_data [0:3];
  logic        frame_rs   [0:3];
  logic        prev_cs = 1'b1, prev_wr = 1'b1, prev_rs = 1'b0;
  logic [15:0] prev_data = '0;
  int          p0;
  logic        seen;

  always #5 clk = ~clk;

  lcd_fifo_printer dut (
    .clk      (clk),
    .rst      (rst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .busy     (busy),
    .LCD_CS   (LCD_CS),
    .LCD_RS   (LCD_RS),
    .LCD_WR   (LCD_WR),
    .LCD_RD   (LCD_RD),
    .LCD_RST  (LCD_RST),
    .LCD_BL   (LCD_BL),
    .LCD_DATA (LCD_DATA)
  );

  assign rempty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rinc) begin
      rdata  <= mem[rd_ptr[3:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  function automatic logic [23:0] outs();
    return {rinc, busy, LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL, LCD_DATA};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear();
    cyc = 0; rinc_cnt = 0; rinc_first = 0; rinc_last = 0; busy_cnt = 0;
    run = 0; run_max = 0; cs_cnt = 0; wr_cnt = 0; rstl_cnt = 0; frames = 0; viol = 0;
    for (int i = 0; i < 4; i++) begin
      frame_data[i] = '0;
      frame_rs[i]   = 1'b0;
    end
  endtask

  // One clock: sample just after the edge and accumulate activity counters.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rinc) begin
      rinc_cnt++;
      if (rinc_first == 0) rinc_first = cyc;
      rinc_last = cyc;
    end
    if (busy) begin
      busy_cnt++;
      run++;
      if (run > run_max) run_max = run;
    end else begin
      run = 0;
    end
    if (!LCD_CS) begin
      cs_cnt++;
      if (prev_cs) frames++;
    end
    if (!LCD_WR) begin
      wr_cnt++;
      if (frames > 0 && frames <= 4) begin
        frame_data[frames-1] = LCD_DATA;
        frame_rs[frames-1]   = LCD_RS;
      end
      if (!prev_wr && (LCD_DATA != prev_data || LCD_RS != prev_rs)) viol++;
    end
    if (!LCD_RST) rstl_cnt++;
    prev_cs = LCD_CS; prev_wr = LCD_WR; prev_rs = LCD_RS; prev_data = LCD_DATA;
  endtask

  initial begin
    rst = 1'b1;
    clear();
    for (int i = 0; i < 3; i++) step();
    chk("reset_outputs", 32'(outs()), 32'h002E_0000);
    rst = 1'b0;

    // Empty FIFO: nothing moves.
    clear();
    for (int i = 0; i < 20; i++) step();
    chk("idle_rinc_cnt", rinc_cnt, 0);
    chk("idle_busy_cnt", busy_cnt, 0);
    chk("idle_outputs", 32'(outs()), 32'h002E_0000);

    // Single CMD write.
    push(32'h0000_002C);
    clear();
    for (int i = 0; i < 12; i++) step();
    chk("cmd_rinc_cnt", rinc_cnt, 1);
    chk("cmd_cs_low", cs_cnt, 5);
    chk("cmd_wr_low", wr_cnt, 2);
    chk("cmd_busy", busy_cnt, 7);
    chk("cmd_data", 32'(frame_data[0]), 32'h0000_002C);
    chk("cmd_rs", 32'(frame_rs[0]), 0);
    chk("cmd_cs_end", 32'(LCD_CS), 1);

    // Back-to-back DATA writes.
    p0 = rd_ptr;
    push(32'h4000_F800);
    push(32'h4000_07E0);
    clear();
    for (int i = 0; i < 20; i++) step();
    chk("dat_frames", frames, 2);
    chk("dat_pops", rd_ptr - p0, 2);
    chk("dat_rinc_first", rinc_first, 1);
    chk("dat_rinc_second", rinc_last, 9);
    chk("dat_data0", 32'(frame_data[0]), 32'h0000_F800);
    chk("dat_data1", 32'(frame_data[1]), 32'h0000_07E0);
    chk("dat_rs", 32'({frame_rs[0], frame_rs[1]}), 32'h3);
    chk("dat_busy", busy_cnt, 14);

    // Zero delay then a 10-cycle delay.
    push(32'h8000_0000);
    push(32'h8000_000A);
    clear();
    for (int i = 0; i < 20; i++) step();
    chk("dly_rinc_second", rinc_last, 4);
    chk("dly_busy_total", busy_cnt, 14);
    chk("dly_busy_run", run_max, 12);
    chk("dly_cs_low", cs_cnt, 0);
    chk("dly_wr_low", wr_cnt, 0);

    // Backlight on with a 5-cycle panel reset pulse.
    push(32'hC300_0005);
    clear();
    for (int i = 0; i < 15; i++) step();
    chk("ctl_rst_low", rstl_cnt, 5);
    chk("ctl_busy", busy_cnt, 7);
    chk("ctl_bl", 32'(LCD_BL), 1);
    chk("ctl_rst_end", 32'(LCD_RST), 1);

    // Backlight off, reset-pulse bit clear.
    push(32'hC000_0003);
    clear();
    for (int i = 0; i < 10; i++) step();
    chk("ctl2_bl", 32'(LCD_BL), 0);
    chk("ctl2_rst_low", rstl_cnt, 0);
    chk("ctl2_busy", busy_cnt, 2);

    // Reset during the write-low phase of a DATA write.
    p0 = rd_ptr;
    push(32'h4000_1234);
    clear();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (!LCD_WR) seen = 1'b1;
    end
    chk("abort_wr_seen", 32'(seen), 1);
    chk("abort_wrlo_data", 32'(LCD_DATA), 32'h0000_1234);
    rst = 1'b1;
    step();
    chk("abort_outputs", 32'(outs()), 32'h002E_0000);
    rst = 1'b0;
    clear();
    for (int i = 0; i < 15; i++) step();
    chk("abort_no_repop", rinc_cnt, 0);
    chk("abort_pops", rd_ptr - p0, 1);
    chk("abort_idle", 32'(outs()), 32'h002E_0000);

    chk("wr_low_stability", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
